max_pooling_2x2: RTL and testbench
==================================

// Module: max_pooling_2x2
// PURPOSE
//  Streaming 2x2/stride-2 max pooling for the segmentation CNN encoder; consumes one conv layer's
//  pixel stream (raster order, one pixel per in_enable) and emits a half-resolution stream with
//  pooled vcnt/hcnt for the next encoder layer. Mirror of the decoder unpooling stage.
// PARAMETERS
//  WIDTH       -1  input frame width in pixels (active columns)
//  HEIGHT      -1  input frame height in pixels (active rows)
//  W_WIDTH     -1  counter range for hcnt; H_BITW = log2(W_WIDTH)
//  W_HEIGHT    -1  counter range for vcnt; V_BITW = log2(W_HEIGHT)
//  FIXED_BITW  -1  bits per unit value, signed two's complement fixed point
//  UNITS       -1  channels per pixel; packed big-endian [0:FIXED_BITW*UNITS-1], unit 0 at MSBs
// PORTS
//  clock       in   1                  single clock, rising edge
//  rst         in   1                  synchronous, active-high reset
//  in_enable   in   1                  in_pixels/in_vcnt/in_hcnt valid this cycle
//  in_pixels   in   FIXED_BITW*UNITS   input pixel, all units
//  in_vcnt     in   V_BITW             input row index
//  in_hcnt     in   H_BITW             input column index
//  out_enable  out  1                  pooled pixel valid (one-cycle pulse)
//  out_pixels  out  FIXED_BITW*UNITS   per-unit max of the 2x2 window
//  out_vcnt    out  V_BITW             in_vcnt>>1 of window (MSB zero)
//  out_hcnt    out  H_BITW             in_hcnt>>1 of window (MSB zero)
// BEHAVIOUR
//  - Reset: out_enable=0, out_pixels=0, out_vcnt=0, out_hcnt=0, left reg=0, all line-buffer valid bits=0.
//  - Window position from in_vcnt[0], in_hcnt[0] on in_enable cycles only; idle cycles change nothing.
//  - (even,even): latch left=in_pixels. (even,odd): write linebuf[in_hcnt>>1]=max(left,in), set valid bit.
//  - (odd,even): latch left; issue linebuf read of [in_hcnt>>1]; read data + valid bit held in a register
//    until next read (gaps in in_enable between the pair allowed).
//  - (odd,odd) at cycle t: out_pixels=max(upper,left,in) per unit, out_enable=1 in cycle t+1 (latency 1);
//    out_vcnt/out_hcnt registered with data. Suppressed (out_enable=0) if held valid bit is 0.
//  - Compare: signed, per unit, no widening; out_pixels held between pulses.
//  - Ties: earliest in raster order wins (UL > UR > LL > LR); affects index output only.
//  - Odd WIDTH: last column ignored (no write, no output). Odd HEIGHT: last row ignored.
//  - Valid bit cleared on read-and-output so stale upper rows never pool twice.
//  - Reset mid-frame: outputs drop next cycle; first pooled output after reset needs a fresh even row.
//  - Line buffer: ceil(WIDTH/2) entries, 1 write + 1 read per pair, sync read (BRAM-inferable).
// CONFIGURATION
//  MAX_POOL_INDEX_EN defined: adds port out_index out 2*UNITS, per-unit winner position
//   {row,col} (00=UL,01=UR,10=LL,11=LR), stored 1 bit per unit in line buffer; registered with
//   out_pixels, reset 0; consumed by an index-driven unpooling variant.
//  Undefined: no out_index port, line buffer holds pixels only.
// STRUCTURE
//  Shared package seg_pkg: log2() (ceil), unit slicing helper, window-position constants
//   UL/UR/LL/LR.
//  Sub-module max_unit: one-unit signed 2-input max with winner select; instanced
//   UNITS x 2 (row pair, then upper vs lower).
// TESTING
//  4x4, UNITS=1, values 0..15 raster -> 4 pulses: 5@(0,0), 7@(0,1), 13@(1,0), 15@(1,1).
//  Negatives: window {-3,-8,-1,-128} (8-bit) -> out=-1; index (if EN)=10.
//  Ties: all four =7 -> out 7, index 00; UR=LR=9 max -> index 01.
//  WIDTH=5, HEIGHT=3 -> 2 outputs only; column 4 and row 2 produce no out_enable.
//  Random 1-3 idle cycles between all in_enable pixels -> same results; each pulse 1 cycle after (odd,odd).
//  rst asserted during row 1 of 4x4 -> out_enable stays 0 for rest of that row; next frame pools correctly.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared helpers for the segmentation CNN pipeline stages
package seg_pkg;

   // Winner positions inside a 2x2 window, {row,col}
   localparam logic [1:0] UL = 2'b00;
   localparam logic [1:0] UR = 2'b01;
   localparam logic [1:0] LL = 2'b10;
   localparam logic [1:0] LR = 2'b11;

   function automatic int log2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Units are packed big-endian: unit 0 occupies the MSBs
   function automatic int unit_lsb(input int unit, input int bitw, input int units);
      return (units - 1 - unit) * bitw;
   endfunction

endpackage

// File: rtl/max_unit.sv
// rtl/max_unit.sv - one-unit signed 2-input max; MAX_POOL_INDEX_EN exposes the winner select
module max_unit #(
   parameter int BITW = 8
) (
   input  logic [BITW-1:0] i_a,
   input  logic [BITW-1:0] i_b,
   output logic [BITW-1:0] o_max
`ifdef MAX_POOL_INDEX_EN
   , output logic          o_sel_b
`endif
);

   logic w_sel_b;

   // Strict compare: on a tie the earlier operand (i_a) wins
   assign w_sel_b = $signed(i_b) > $signed(i_a);
   assign o_max   = w_sel_b ? i_b : i_a;

`ifdef MAX_POOL_INDEX_EN
   assign o_sel_b = w_sel_b;
`endif

endmodule

// File: rtl/max_pooling_2x2.sv
// rtl/max_pooling_2x2.sv - streaming 2x2/stride-2 max pooling; MAX_POOL_INDEX_EN adds out_index
module max_pooling_2x2
   import seg_pkg::*;
#(
   parameter int  WIDTH      = 4,
   parameter int  HEIGHT     = 4,
   parameter int  W_WIDTH    = 4,
   parameter int  W_HEIGHT   = 4,
   parameter int  FIXED_BITW = 8,
   parameter int  UNITS      = 1,
   localparam int H_BITW     = log2(W_WIDTH),
   localparam int V_BITW     = log2(W_HEIGHT),
   localparam int PIX_W      = FIXED_BITW * UNITS
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              in_enable,
   input  logic [PIX_W-1:0]  in_pixels,
   input  logic [V_BITW-1:0] in_vcnt,
   input  logic [H_BITW-1:0] in_hcnt,
   output logic              out_enable,
   output logic [PIX_W-1:0]  out_pixels,
   output logic [V_BITW-1:0] out_vcnt,
   output logic [H_BITW-1:0] out_hcnt
`ifdef MAX_POOL_INDEX_EN
   , output logic [2*UNITS-1:0] out_index
`endif
);

   localparam int DEPTH  = (WIDTH + 1) / 2;
   localparam int A_BITW = (log2(DEPTH) < 1) ? 1 : log2(DEPTH);
`ifdef MAX_POOL_INDEX_EN
   localparam int MEM_W  = PIX_W + UNITS;
`else
   localparam int MEM_W  = PIX_W;
`endif

   logic [MEM_W-1:0]  r_mem [DEPTH];
   logic [DEPTH-1:0]  r_valid;
   logic [MEM_W-1:0]  r_rd_data;
   logic              r_rd_valid;
   logic [PIX_W-1:0]  r_left;
   logic              r_out_en;
   logic [PIX_W-1:0]  r_out_pix;
   logic [V_BITW-1:0] r_out_v;
   logic [H_BITW-1:0] r_out_h;

   logic [A_BITW-1:0] w_addr;
   logic              w_col_ok, w_row_ok, w_wr_en, w_rd_en, w_pool;
   logic [PIX_W-1:0]  w_pair_max, w_out_max, w_upper_pix;
   logic [MEM_W-1:0]  w_wr_data;

   // Trailing odd column/row has no partner and is dropped
   assign w_col_ok = (32'(in_hcnt) >> 1) < 32'(WIDTH / 2);
   assign w_row_ok = (32'(in_vcnt) >> 1) < 32'(HEIGHT / 2);
   assign w_addr   = A_BITW'(in_hcnt >> 1);

   assign w_wr_en = in_enable & ~in_vcnt[0] &  in_hcnt[0] & w_col_ok & w_row_ok;
   assign w_rd_en = in_enable &  in_vcnt[0] & ~in_hcnt[0] & w_col_ok & w_row_ok;
   assign w_pool  = in_enable &  in_vcnt[0] &  in_hcnt[0] & w_col_ok & w_row_ok;

   assign w_upper_pix = r_rd_data[MEM_W-1 -: PIX_W];

`ifdef MAX_POOL_INDEX_EN
   logic [UNITS-1:0]   w_pair_col, w_upper_col, w_out_row;
   logic [2*UNITS-1:0] w_out_idx, r_out_idx;
   assign w_wr_data   = {w_pair_max, w_pair_col};
   assign w_upper_col = r_rd_data[UNITS-1:0];
   assign out_index   = r_out_idx;
`else
   assign w_wr_data   = w_pair_max;
`endif

   for (genvar u = 0; u < UNITS; u++) begin : g_unit
      localparam int LSB = unit_lsb(u, FIXED_BITW, UNITS);

      max_unit #(.BITW(FIXED_BITW)) u_pair (
         .i_a   (r_left[LSB +: FIXED_BITW]),
         .i_b   (in_pixels[LSB +: FIXED_BITW]),
         .o_max (w_pair_max[LSB +: FIXED_BITW])
`ifdef MAX_POOL_INDEX_EN
         , .o_sel_b (w_pair_col[u])
`endif
      );

      max_unit #(.BITW(FIXED_BITW)) u_vert (
         .i_a   (w_upper_pix[LSB +: FIXED_BITW]),
         .i_b   (w_pair_max[LSB +: FIXED_BITW]),
         .o_max (w_out_max[LSB +: FIXED_BITW])
`ifdef MAX_POOL_INDEX_EN
         , .o_sel_b (w_out_row[u])
`endif
      );

`ifdef MAX_POOL_INDEX_EN
      assign w_out_idx[2*(UNITS-1-u) +: 2] =
         {w_out_row[u], w_out_row[u] ? w_pair_col[u] : w_upper_col[u]};
`endif
   end

   // Line buffer storage without reset so it maps onto block RAM
   always_ff @(posedge clock) begin
      if (w_wr_en) r_mem[w_addr] <= w_wr_data;
      if (w_rd_en) r_rd_data <= r_mem[w_addr];
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         r_left     <= '0;
         r_valid    <= '0;
         r_rd_valid <= 1'b0;
         r_out_en   <= 1'b0;
         r_out_pix  <= '0;
         r_out_v    <= '0;
         r_out_h    <= '0;
`ifdef MAX_POOL_INDEX_EN
         r_out_idx  <= '0;
`endif
      end else begin
         r_out_en <= 1'b0;
         if (in_enable && !in_hcnt[0]) r_left <= in_pixels;
         if (w_wr_en) r_valid[w_addr] <= 1'b1;
         if (w_rd_en) r_rd_valid <= r_valid[w_addr];
         if (w_pool) begin
            // Consume the upper half so it can never pool twice
            r_valid[w_addr] <= 1'b0;
            r_rd_valid      <= 1'b0;
            if (r_rd_valid) begin
               r_out_en  <= 1'b1;
               r_out_pix <= w_out_max;
               r_out_v   <= in_vcnt >> 1;
               r_out_h   <= in_hcnt >> 1;
`ifdef MAX_POOL_INDEX_EN
               r_out_idx <= w_out_idx;
`endif
            end
         end
      end
   end

   assign out_enable = r_out_en;
   assign out_pixels = r_out_pix;
   assign out_vcnt   = r_out_v;
   assign out_hcnt   = r_out_h;

endmodule

// File: tb/tb_max_pooling_2x2.sv
// tb/tb_max_pooling_2x2.sv - directed bench for max_pooling_2x2 (MAX_POOL_INDEX_EN optional)
module tb_max_pooling_2x2;

   logic        clock = 1'b0;
   logic        rst = 1'b1;
   logic        en4 = 1'b0, en5 = 1'b0;
   logic [15:0] pix4 = '0;
   logic [7:0]  pix5 = '0;
   logic [1:0]  vc = '0;
   logic [1:0]  hc4 = '0;
   logic [2:0]  hc5 = '0;

   logic        o_en4, o_en5;
   logic [15:0] o_pix4;
   logic [7:0]  o_pix5;
   logic [1:0]  o_vc4, o_vc5, o_hc4;
   logic [2:0]  o_hc5;
`ifdef MAX_POOL_INDEX_EN
   logic [3:0]  o_idx4;
   logic [1:0]  o_idx5;
`endif

   int          checks = 0;
   int          errors = 0;
   logic        obs_en, late_en;
   logic [15:0] obs_pix;
   logic [1:0]  obs_v;
   logic [2:0]  obs_h;
   logic [3:0]  obs_idx;

   always #5 clock = ~clock;

   max_pooling_2x2 #(.WIDTH(4), .HEIGHT(4), .W_WIDTH(4), .W_HEIGHT(4),
                     .FIXED_BITW(8), .UNITS(2)) u_dut4 (
      .clock(clock), .rst(rst), .in_enable(en4), .in_pixels(pix4),
      .in_vcnt(vc), .in_hcnt(hc4), .out_enable(o_en4), .out_pixels(o_pix4),
      .out_vcnt(o_vc4), .out_hcnt(o_hc4)
`ifdef MAX_POOL_INDEX_EN
      , .out_index(o_idx4)
`endif
   );

   max_pooling_2x2 #(.WIDTH(5), .HEIGHT(3), .W_WIDTH(8), .W_HEIGHT(4),
                     .FIXED_BITW(8), .UNITS(1)) u_dut5 (
      .clock(clock), .rst(rst), .in_enable(en5), .in_pixels(pix5),
      .in_vcnt(vc), .in_hcnt(hc5), .out_enable(o_en5), .out_pixels(o_pix5),
      .out_vcnt(o_vc5), .out_hcnt(o_hc5)
`ifdef MAX_POOL_INDEX_EN
      , .out_index(o_idx5)
`endif
   );

   // Called at a falling edge; drives one pixel for one cycle, samples the next falling edge
   task automatic px(input bit sel5, input logic [15:0] p, input logic [1:0] v,
                     input logic [2:0] h, input int gap);
      pix4 = p; pix5 = p[7:0]; vc = v; hc4 = h[1:0]; hc5 = h;
      if (sel5) en5 = 1'b1; else en4 = 1'b1;
      @(negedge clock);
      en4 = 1'b0; en5 = 1'b0;
      obs_en  = sel5 ? o_en5 : o_en4;
      obs_pix = sel5 ? {8'h00, o_pix5} : o_pix4;
      obs_v   = sel5 ? o_vc5 : o_vc4;
      obs_h   = sel5 ? o_hc5 : {1'b0, o_hc4};
`ifdef MAX_POOL_INDEX_EN
      obs_idx = sel5 ? {2'b00, o_idx5} : o_idx4;
`else
      obs_idx = 4'h0;
`endif
      late_en = 1'b0;
      for (int i = 0; i < gap; i++) begin
         @(negedge clock);
         late_en = late_en | (sel5 ? o_en5 : o_en4);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clock);
      checks++;
      if (o_en4 !== 1'b0 || o_pix4 !== 16'h0 || o_vc4 !== 2'd0 || o_hc4 !== 2'd0) begin
         errors++;
         $display("FAIL reset_dut4 got en=%b pix=%h v=%0d h=%0d want 0", o_en4, o_pix4, o_vc4, o_hc4);
      end
      checks++;
      if (o_en5 !== 1'b0 || o_pix5 !== 8'h0 || o_vc5 !== 2'd0 || o_hc5 !== 3'd0) begin
         errors++;
         $display("FAIL reset_dut5 got en=%b pix=%h v=%0d h=%0d want 0", o_en5, o_pix5, o_vc5, o_hc5);
      end
`ifdef MAX_POOL_INDEX_EN
      checks++;
      if (o_idx4 !== 4'h0) begin
         errors++;
         $display("FAIL reset_index got %b want 0000", o_idx4);
      end
`endif
      rst = 1'b0;
   endtask

   // 4x4 raster 0..15 on unit 0, 15-value on unit 1
   task automatic test_raster(input string name, input bit gaps);
      logic [15:0] exp_pix [4] = '{16'h050F, 16'h070D, 16'h0D07, 16'h0F05};
      int k;
      int gap;
      k = 0;
      for (int v = 0; v < 4; v++) begin
         for (int h = 0; h < 4; h++) begin
            logic [7:0] val;
            val = 8'(v * 4 + h);
            gap = gaps ? int'($urandom_range(1, 3)) : 0;
            px(1'b0, {val, 8'd15 - val}, 2'(v), 3'(h), gap);
            checks++;
            if (v % 2 == 1 && h % 2 == 1) begin
               if (obs_en !== 1'b1 || obs_pix !== exp_pix[k] || obs_v !== 2'(v / 2) || obs_h !== 3'(h / 2)) begin
                  errors++;
                  $display("FAIL %s_out%0d got en=%b pix=%h v=%0d h=%0d want 1 %h %0d %0d",
                           name, k, obs_en, obs_pix, obs_v, obs_h, exp_pix[k], v / 2, h / 2);
               end
`ifdef MAX_POOL_INDEX_EN
               checks++;
               if (obs_idx !== 4'b1100) begin
                  errors++;
                  $display("FAIL %s_idx%0d got %b want 1100", name, k, obs_idx);
               end
`endif
               if (gaps) begin
                  checks++;
                  if (late_en !== 1'b0) begin
                     errors++;
                     $display("FAIL %s_pulse_width%0d got late_en=%b want 0", name, k, late_en);
                  end
               end
               k++;
            end else if (obs_en !== 1'b0) begin
               errors++;
               $display("FAIL %s_no_pulse v=%0d h=%0d got en=%b want 0", name, v, h, obs_en);
            end
         end
      end
      checks++;
      if (o_pix4 !== 16'h0F05) begin
         errors++;
         $display("FAIL %s_hold got pix=%h want 0f05", name, o_pix4);
      end
   endtask

   task automatic test_negative();
      px(1'b0, 16'hFD01, 2'd0, 3'd0, 0);
      px(1'b0, 16'hF87F, 2'd0, 3'd1, 0);
      px(1'b0, 16'hFF80, 2'd1, 3'd0, 0);
      px(1'b0, 16'h807F, 2'd1, 3'd1, 0);
      checks++;
      if (obs_en !== 1'b1 || obs_pix !== 16'hFF7F || obs_v !== 2'd0 || obs_h !== 3'd0) begin
         errors++;
         $display("FAIL negative got en=%b pix=%h v=%0d h=%0d want 1 ff7f 0 0", obs_en, obs_pix, obs_v, obs_h);
      end
`ifdef MAX_POOL_INDEX_EN
      checks++;
      if (obs_idx !== 4'b1001) begin
         errors++;
         $display("FAIL negative_idx got %b want 1001", obs_idx);
      end
`endif
   endtask

   task automatic test_ties();
      px(1'b0, 16'h0703, 2'd2, 3'd2, 1);
      px(1'b0, 16'h0709, 2'd2, 3'd3, 2);
      px(1'b0, 16'h0702, 2'd3, 3'd2, 3);
      px(1'b0, 16'h0709, 2'd3, 3'd3, 0);
      checks++;
      if (obs_en !== 1'b1 || obs_pix !== 16'h0709 || obs_v !== 2'd1 || obs_h !== 3'd1) begin
         errors++;
         $display("FAIL ties got en=%b pix=%h v=%0d h=%0d want 1 0709 1 1", obs_en, obs_pix, obs_v, obs_h);
      end
`ifdef MAX_POOL_INDEX_EN
      checks++;
      if (obs_idx !== 4'b0001) begin
         errors++;
         $display("FAIL ties_idx got %b want 0001", obs_idx);
      end
`endif
   endtask

   // 5x3 frame, values 0..14: windows {0,1,5,6} and {2,3,7,8}
   task automatic test_odd_size();
      for (int v = 0; v < 3; v++) begin
         for (int h = 0; h < 5; h++) begin
            px(1'b1, 16'(v * 5 + h), 2'(v), 3'(h), 0);
            checks++;
            if (v == 1 && (h == 1 || h == 3)) begin
               if (obs_en !== 1'b1 || obs_pix !== 16'(h == 1 ? 6 : 8) || obs_v !== 2'd0 || obs_h !== 3'(h / 2)) begin
                  errors++;
                  $display("FAIL odd_out h=%0d got en=%b pix=%h v=%0d h=%0d want 1 %0d 0 %0d",
                           h, obs_en, obs_pix, obs_v, obs_h, (h == 1 ? 6 : 8), h / 2);
               end
            end else if (obs_en !== 1'b0) begin
               errors++;
               $display("FAIL odd_no_pulse v=%0d h=%0d got en=%b want 0", v, h, obs_en);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int h = 0; h < 4; h++) px(1'b0, {8'(h), 8'(h)}, 2'd0, 3'(h), 0);
      px(1'b0, 16'h0404, 2'd1, 3'd0, 0);
      rst = 1'b1;
      @(negedge clock);
      rst = 1'b0;
      checks++;
      if (o_en4 !== 1'b0 || o_pix4 !== 16'h0) begin
         errors++;
         $display("FAIL mid_reset_out got en=%b pix=%h want 0 0000", o_en4, o_pix4);
      end
      for (int h = 1; h < 4; h++) begin
         px(1'b0, {8'(4 + h), 8'(4 + h)}, 2'd1, 3'(h), 0);
         checks++;
         if (obs_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_row1 h=%0d got en=%b want 0", h, obs_en);
         end
      end
   endtask

   initial begin
      test_reset();
      test_raster("raster", 1'b0);
      test_negative();
      test_ties();
      test_odd_size();
      test_raster("gaps", 1'b1);
      test_reset_mid();
      test_raster("after_reset", 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
